// File: rtl/round_timer_if.sv
// Bus bundle for round_timer: tick input, round control, countdown/BCD outputs.
// The optional bonus-time handshake exists only when ROUND_TIMER_BONUS_EN is defined.
interface round_timer_if #(
  parameter int TICK_W = 20,
  parameter int REM_W  = 17
);
  logic [TICK_W-1:0] tick_count;
  logic              start;
  logic              pause;
  logic [REM_W-1:0]  remaining_cs;
  logic              running;
  logic              done;
  logic              expired;
  logic [3:0]        sec_h;
  logic [3:0]        sec_t;
  logic [3:0]        sec_o;
  logic [3:0]        cs_t;
  logic [3:0]        cs_o;
  logic              bcd_valid;
`ifdef ROUND_TIMER_BONUS_EN
  logic              add_valid;
  logic [REM_W-1:0]  add_cs;
  logic              add_ready;

  modport master (
    output tick_count, start, pause, add_valid, add_cs,
    input  remaining_cs, running, done, expired,
    input  sec_h, sec_t, sec_o, cs_t, cs_o, bcd_valid, add_ready
  );

  modport slave (
    input  tick_count, start, pause, add_valid, add_cs,
    output remaining_cs, running, done, expired,
    output sec_h, sec_t, sec_o, cs_t, cs_o, bcd_valid, add_ready
  );
`else
  modport master (
    output tick_count, start, pause,
    input  remaining_cs, running, done, expired,
    input  sec_h, sec_t, sec_o, cs_t, cs_o, bcd_valid
  );

  modport slave (
    input  tick_count, start, pause,
    output remaining_cs, running, done, expired,
    output sec_h, sec_t, sec_o, cs_t, cs_o, bcd_valid
  );
`endif
endinterface

// File: rtl/round_timer.sv
// Round countdown driven by a free-running, wrapping centisecond count, with SSS.cc BCD
// digits built by repeated subtraction. Define ROUND_TIMER_BONUS_EN to add the bonus-time input.
module round_timer #(
  parameter int TICK_W   = 20,
  parameter int TICK_MAX = 1000001,
  parameter int ROUND_CS = 6000,
  parameter int MAX_CS   = 99999,
  parameter int REM_W    = 17
) (
  input logic          clk,
  input logic          reset_n,
  round_timer_if.slave tmr
);
  localparam int DW = TICK_W + 1;
  localparam int CW = (DW > REM_W + 1) ? DW : REM_W + 1;
  localparam logic [DW-1:0]    SPAN      = DW'(TICK_MAX + 1);
  localparam logic [REM_W-1:0] ROUND_VAL = REM_W'(ROUND_CS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  function automatic logic [REM_W-1:0] sat0(input logic [REM_W-1:0] rem,
                                            input logic [DW-1:0] d);
    logic [CW-1:0] r;
    logic [CW-1:0] dd;
    r  = CW'(rem);
    dd = CW'(d);
    if (dd >= r) sat0 = '0;
    else         sat0 = REM_W'(r - dd);
  endfunction

`ifdef ROUND_TIMER_BONUS_EN
  localparam logic [REM_W:0] MAX_W = (REM_W+1)'(MAX_CS);

  function automatic logic [REM_W-1:0] sat_max(input logic [REM_W-1:0] a,
                                               input logic [REM_W-1:0] b);
    logic [REM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > MAX_W) sat_max = MAX_W[REM_W-1:0];
    else           sat_max = s[REM_W-1:0];
  endfunction
`endif

  function automatic logic [REM_W-1:0] weight(input logic [1:0] p);
    case (p)
      2'd0:    weight = REM_W'(10000);
      2'd1:    weight = REM_W'(1000);
      2'd2:    weight = REM_W'(100);
      default: weight = REM_W'(10);
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [TICK_W-1:0] prev_tick;
  logic              primed;
  logic [REM_W-1:0]  rem_q, rem_d, dec;
  logic              expired_q, expired_d;
  logic [DW-1:0]     delta_raw, delta;

  // Elapsed ticks since last cycle; the source wraps from TICK_MAX to 0.
  assign delta_raw = (tmr.tick_count >= prev_tick)
                   ? {1'b0, tmr.tick_count} - {1'b0, prev_tick}
                   : {1'b0, tmr.tick_count} + SPAN - {1'b0, prev_tick};
  assign delta     = (!primed || tmr.start) ? '0 : delta_raw;
  assign dec       = sat0(rem_q, delta);

`ifdef ROUND_TIMER_BONUS_EN
  logic add_ready_i;
  logic add_fire;
  assign add_ready_i   = (state_q == RUN) || (state_q == PAUSE);
  assign add_fire      = tmr.add_valid && add_ready_i;
  assign tmr.add_ready = add_ready_i;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      prev_tick <= '0;
      primed    <= 1'b0;
      rem_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_tick <= tmr.tick_count;
      primed    <= 1'b1;
      rem_q     <= rem_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    if (tmr.start) begin
      rem_d   = ROUND_VAL;
      state_d = tmr.pause ? PAUSE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (tmr.pause) begin
            state_d = PAUSE;
`ifdef ROUND_TIMER_BONUS_EN
            if (add_fire) rem_d = sat_max(rem_q, tmr.add_cs);
`endif
          end else begin
            rem_d = dec;
`ifdef ROUND_TIMER_BONUS_EN
            if (add_fire) rem_d = sat_max(dec, tmr.add_cs);
`endif
            if (rem_d == '0) begin
              state_d   = EXPIRED;
              expired_d = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!tmr.pause) state_d = RUN;
`ifdef ROUND_TIMER_BONUS_EN
          if (add_fire) rem_d = sat_max(rem_q, tmr.add_cs);
`endif
        end
        EXPIRED: rem_d = '0;
        default: ;
      endcase
    end
  end

  logic [REM_W-1:0] conv_src, work, w_cur, work_sub;
  logic [1:0]       pos;
  logic             busy, ge, step_done, bcd_valid_q;
  logic [3:0]       acc [4];
  logic [3:0]       dig [5];
  logic [3:0]       acc_inc;

  // One subtraction per cycle; move to the next weight once the remainder drops below it.
  assign w_cur     = weight(pos);
  assign ge        = (work >= w_cur);
  assign work_sub  = ge ? work - w_cur : work;
  assign acc_inc   = acc[pos] + {3'b000, ge};
  assign step_done = (work_sub < w_cur);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conv_src    <= '0;
      work        <= '0;
      pos         <= 2'd0;
      busy        <= 1'b0;
      bcd_valid_q <= 1'b1;
      for (int i = 0; i < 4; i++) acc[i] <= 4'd0;
      for (int i = 0; i < 5; i++) dig[i] <= 4'd0;
    end else if (rem_q != conv_src) begin
      conv_src    <= rem_q;
      work        <= rem_q;
      pos         <= 2'd0;
      busy        <= 1'b1;
      bcd_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) acc[i] <= 4'd0;
    end else if (busy) begin
      work     <= work_sub;
      acc[pos] <= acc_inc;
      if (step_done) begin
        if (pos == 2'd3) begin
          busy        <= 1'b0;
          bcd_valid_q <= 1'b1;
          dig[0]      <= acc[0];
          dig[1]      <= acc[1];
          dig[2]      <= acc[2];
          dig[3]      <= acc_inc;
          dig[4]      <= work_sub[3:0];
        end else begin
          pos <= pos + 2'd1;
        end
      end
    end
  end

  assign tmr.remaining_cs = rem_q;
  assign tmr.running      = (state_q == RUN);
  assign tmr.done         = (state_q == EXPIRED);
  assign tmr.expired      = expired_q;
  assign tmr.sec_h        = dig[0];
  assign tmr.sec_t        = dig[1];
  assign tmr.sec_o        = dig[2];
  assign tmr.cs_t         = dig[3];
  assign tmr.cs_o         = dig[4];
  assign tmr.bcd_valid    = bcd_valid_q;
endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: countdown, tick wrap, pause, saturation, start priority, reset.
module tb_round_timer;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  round_timer_if #(.TICK_W(20), .REM_W(17)) tmr ();

  round_timer dut (
    .clk    (clk),
    .reset_n(reset_n),
    .tmr    (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_tick(input int v, input int hold);
    tmr.tick_count = v[19:0];
    cyc(hold);
  endtask

  task automatic pulse_start();
    tmr.start = 1'b1;
    cyc(1);
    tmr.start = 1'b0;
  endtask

  task automatic wait_bcd(output bit ok);
    ok = 1'b0;
    cyc(2);
    for (int i = 0; i < 80; i++) begin
      if (tmr.bcd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  function automatic logic [19:0] digits();
    return {tmr.sec_h, tmr.sec_t, tmr.sec_o, tmr.cs_t, tmr.cs_o};
  endfunction

  task automatic do_reset(input int tick0);
    reset_n        = 1'b0;
    tmr.tick_count = tick0[19:0];
    tmr.start      = 1'b0;
    tmr.pause      = 1'b0;
`ifdef ROUND_TIMER_BONUS_EN
    tmr.add_valid  = 1'b0;
    tmr.add_cs     = '0;
`endif
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tmr.tick_count = '0;
    tmr.start = 1'b0;
    tmr.pause = 1'b0;
`ifdef ROUND_TIMER_BONUS_EN
    tmr.add_valid = 1'b0;
    tmr.add_cs    = '0;
`endif
    cyc(3);
    total++;
    if ({tmr.remaining_cs, tmr.running, tmr.done, tmr.expired, tmr.bcd_valid} !== {17'd0, 4'b0001}) begin
      bad++;
      $display("FAIL reset_outputs: got rem=%0d run=%b done=%b exp=%b bv=%b want 0 0 0 0 1",
               tmr.remaining_cs, tmr.running, tmr.done, tmr.expired, tmr.bcd_valid);
    end
    total++;
    if (digits() !== 20'h00000) begin
      bad++;
      $display("FAIL reset_digits: got %h want 00000", digits());
    end
    reset_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_countdown();
    int exp_cnt;
    int exp_at;
    bit ok;
    do_reset(0);
    pulse_start();
    exp_cnt = 0;
    exp_at  = -1;
    for (int t = 1; t <= 6000; t++) begin
      tmr.tick_count = t[19:0];
      for (int k = 0; k < 4; k++) begin
        cyc(1);
        if (tmr.expired === 1'b1) begin
          exp_cnt++;
          exp_at = t;
        end
      end
      if (t == 3000) begin
        total++;
        if (tmr.remaining_cs !== 17'd3000 || tmr.running !== 1'b1) begin
          bad++;
          $display("FAIL countdown_mid: got rem=%0d run=%b want 3000 1", tmr.remaining_cs, tmr.running);
        end
      end
    end
    total++;
    if (exp_cnt !== 1 || exp_at !== 6000) begin
      bad++;
      $display("FAIL countdown_expired_pulse: got count=%0d at=%0d want 1 at 6000", exp_cnt, exp_at);
    end
    total++;
    if (tmr.done !== 1'b1 || tmr.running !== 1'b0 || tmr.remaining_cs !== 17'd0) begin
      bad++;
      $display("FAIL countdown_done: got done=%b run=%b rem=%0d want 1 0 0", tmr.done, tmr.running, tmr.remaining_cs);
    end
    wait_bcd(ok);
    total++;
    if (ok !== 1'b1 || digits() !== 20'h00000) begin
      bad++;
      $display("FAIL countdown_digits: got valid=%b digits=%h want 1 00000", ok, digits());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(1000000);
    pulse_start();
    set_tick(1000001, 2);
    set_tick(0, 2);
    set_tick(1, 2);
    total++;
    if (tmr.remaining_cs !== 17'd5997) begin
      bad++;
      $display("FAIL wrap_remaining: got %0d want 5997", tmr.remaining_cs);
    end
    wait_bcd(ok);
    total++;
    if (ok !== 1'b1 || digits() !== 20'h05997) begin
      bad++;
      $display("FAIL wrap_digits: got valid=%b digits=%h want 1 05997", ok, digits());
    end
  endtask

  task automatic test_pause();
    bit run_seen;
    do_reset(0);
    pulse_start();
    for (int t = 1; t <= 10; t++) set_tick(t, 2);
    total++;
    if (tmr.remaining_cs !== 17'd5990) begin
      bad++;
      $display("FAIL pause_before: got %0d want 5990", tmr.remaining_cs);
    end
    tmr.pause = 1'b1;
    cyc(1);
    run_seen = 1'b0;
    for (int t = 11; t <= 60; t++) begin
      tmr.tick_count = t[19:0];
      for (int k = 0; k < 2; k++) begin
        cyc(1);
        if (tmr.running !== 1'b0) run_seen = 1'b1;
      end
    end
    total++;
    if (run_seen !== 1'b0 || tmr.remaining_cs !== 17'd5990) begin
      bad++;
      $display("FAIL pause_hold: got running_seen=%b rem=%0d want 0 5990", run_seen, tmr.remaining_cs);
    end
    tmr.pause = 1'b0;
    cyc(2);
    total++;
    if (tmr.running !== 1'b1) begin
      bad++;
      $display("FAIL pause_release: got running=%b want 1", tmr.running);
    end
    for (int t = 61; t <= 70; t++) set_tick(t, 2);
    total++;
    if (tmr.remaining_cs !== 17'd5980) begin
      bad++;
      $display("FAIL pause_after: got %0d want 5980", tmr.remaining_cs);
    end
  endtask

  task automatic test_saturate();
    do_reset(0);
    pulse_start();
    set_tick(5997, 2);
    total++;
    if (tmr.remaining_cs !== 17'd3 || tmr.running !== 1'b1) begin
      bad++;
      $display("FAIL sat_setup: got rem=%0d run=%b want 3 1", tmr.remaining_cs, tmr.running);
    end
    tmr.tick_count = 20'd6004;
    cyc(1);
    total++;
    if (tmr.remaining_cs !== 17'd0 || tmr.expired !== 1'b1) begin
      bad++;
      $display("FAIL sat_expire: got rem=%0d exp=%b want 0 1", tmr.remaining_cs, tmr.expired);
    end
    cyc(1);
    total++;
    if (tmr.expired !== 1'b0 || tmr.done !== 1'b1 || tmr.remaining_cs !== 17'd0) begin
      bad++;
      $display("FAIL sat_after: got exp=%b done=%b rem=%0d want 0 1 0", tmr.expired, tmr.done, tmr.remaining_cs);
    end
  endtask

  task automatic test_start_pause();
    bit ok;
    do_reset(100);
    tmr.pause = 1'b1;
    pulse_start();
    total++;
    if (tmr.running !== 1'b0 || tmr.done !== 1'b0 || tmr.remaining_cs !== 17'd6000) begin
      bad++;
      $display("FAIL start_pause_state: got run=%b done=%b rem=%0d want 0 0 6000",
               tmr.running, tmr.done, tmr.remaining_cs);
    end
    set_tick(140, 2);
    wait_bcd(ok);
    total++;
    if (tmr.remaining_cs !== 17'd6000 || ok !== 1'b1 || digits() !== 20'h06000) begin
      bad++;
      $display("FAIL start_pause_digits: got rem=%0d valid=%b digits=%h want 6000 1 06000",
               tmr.remaining_cs, ok, digits());
    end
    tmr.pause = 1'b0;
    cyc(1);
    total++;
    if (tmr.running !== 1'b1) begin
      bad++;
      $display("FAIL start_pause_release: got running=%b want 1", tmr.running);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    pulse_start();
    set_tick(250, 2);
    pulse_start();
    total++;
    if (tmr.remaining_cs !== 17'd6000 || tmr.running !== 1'b1) begin
      bad++;
      $display("FAIL restart_reload: got rem=%0d run=%b want 6000 1", tmr.remaining_cs, tmr.running);
    end
    set_tick(6247, 2);
    tmr.tick_count = 20'd6300;
    tmr.start      = 1'b1;
    cyc(1);
    tmr.start = 1'b0;
    total++;
    if (tmr.remaining_cs !== 17'd6000 || tmr.expired !== 1'b0 || tmr.running !== 1'b1) begin
      bad++;
      $display("FAIL start_over_expiry: got rem=%0d exp=%b run=%b want 6000 0 1",
               tmr.remaining_cs, tmr.expired, tmr.running);
    end
  endtask

`ifdef ROUND_TIMER_BONUS_EN
  task automatic test_bonus();
    bit ok;
    do_reset(0);
    total++;
    if (tmr.add_ready !== 1'b0) begin
      bad++;
      $display("FAIL bonus_ready_idle: got %b want 0", tmr.add_ready);
    end
    pulse_start();
    tmr.add_valid = 1'b1;
    tmr.add_cs    = 17'd93990;
    cyc(1);
    total++;
    if (tmr.remaining_cs !== 17'd99990) begin
      bad++;
      $display("FAIL bonus_first: got %0d want 99990", tmr.remaining_cs);
    end
    tmr.add_cs = 17'd50;
    cyc(1);
    tmr.add_valid = 1'b0;
    total++;
    if (tmr.remaining_cs !== 17'd99999 || tmr.add_ready !== 1'b1) begin
      bad++;
      $display("FAIL bonus_saturate: got rem=%0d ready=%b want 99999 1", tmr.remaining_cs, tmr.add_ready);
    end
    wait_bcd(ok);
    total++;
    if (ok !== 1'b1 || digits() !== 20'h99999) begin
      bad++;
      $display("FAIL bonus_digits: got valid=%b digits=%h want 1 99999", ok, digits());
    end
  endtask
`endif

  task automatic test_reset_mid_run();
    bit ok;
    do_reset(0);
    pulse_start();
    set_tick(1234, 2);
    wait_bcd(ok);
    total++;
    if (ok !== 1'b1 || digits() !== 20'h04766) begin
      bad++;
      $display("FAIL midrun_digits: got valid=%b digits=%h want 1 04766", ok, digits());
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({tmr.remaining_cs, tmr.running, tmr.done, tmr.expired, tmr.bcd_valid} !== {17'd0, 4'b0001} ||
        digits() !== 20'h00000) begin
      bad++;
      $display("FAIL midrun_reset: got rem=%0d run=%b done=%b exp=%b bv=%b digits=%h want 0 0 0 0 1 00000",
               tmr.remaining_cs, tmr.running, tmr.done, tmr.expired, tmr.bcd_valid, digits());
    end
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_countdown();
    test_wrap();
    test_pause();
    test_saturate();
    test_start_pause();
    test_back_to_back();
`ifdef ROUND_TIMER_BONUS_EN
    test_bonus();
`endif
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
